// File: rtl/option_sequencer.sv
// Circular option queue feeding the line solver: streams header/option words, writes back kept options.
// Optional build macro SEQ_STATS_EN adds pass_cnt/drop_cnt saturating statistics outputs.
module option_sequencer #(
  parameter int SIZE         = 3,
  parameter int DEPTH        = 64,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic            load_hdr,
  input  logic [SIZE-1:0] load_data,
  output logic            load_ready,
  input  logic            load_done,
  output logic [SIZE-1:0] option,
  output logic            valid_op,
  output logic            is_hdr,
  output logic            started,
  input  logic            pb_valid,
  input  logic            pb_keep,
  input  logic            solved,
  output logic            stuck,
  output logic            done
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0]     pass_cnt,
  output logic [15:0]     drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [IW-1:0] INF_MAX  = IW'(MAX_INFLIGHT);
  localparam logic [IW-1:0] INF_ONE  = IW'(1);
  localparam logic [PW-1:0] PND_LAST = PW'(MAX_INFLIGHT - 1);
  localparam logic [PW-1:0] PND_ONE  = PW'(1);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_STUCK = 3'd4;

  logic [SIZE:0]   mem [DEPTH];
  logic [SIZE-1:0] pend [MAX_INFLIGHT];

  logic [2:0]      state_reg, state_next;
  logic [AW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]     count_reg;
  logic [IW-1:0]   inflight_reg;
  logic [PW-1:0]   pend_rd_reg, pend_wr_reg;
  logic            drop_flag_reg;

  logic [SIZE:0]   head;
  logic [AW:0]     occ;
  logic            head_avail, in_run, full;
  logic            accept, issue_opt, issue_hdr, verdict, drop, pass_close, pop;
  logic            wr_en;
  logic [SIZE:0]   wr_data;

  // count also covers options sitting in the pending FIFO, so the physical queue holds count - inflight
  assign head       = mem[rd_ptr_reg];
  assign occ        = count_reg - (AW+1)'(inflight_reg);
  assign head_avail = (occ != '0);
  assign in_run     = (state_reg == S_RUN);
  assign full       = (count_reg == CNT_FULL);

  assign load_ready = (state_reg == S_LOAD) && !full;
  assign accept     = load_valid && load_ready;

  assign issue_opt  = in_run && !solved && head_avail && !head[SIZE] && (inflight_reg < INF_MAX);
  // header issue waits for all verdicts so its write-back never collides with an option write-back
  assign issue_hdr  = !solved && ((state_reg == S_START) ||
                      (in_run && head_avail && head[SIZE] && (inflight_reg == '0) && !pb_valid));
  assign verdict    = in_run && !solved && pb_valid && (inflight_reg != '0);
  assign drop       = verdict && !pb_keep;
  assign pass_close = in_run && issue_hdr && (head[SIZE-1:0] == '0);
  assign pop        = issue_opt || issue_hdr;

  assign wr_en   = accept || issue_hdr || (verdict && pb_keep);
  assign wr_data = accept    ? {load_hdr, load_data} :
                   issue_hdr ? head : {1'b0, pend[pend_rd_reg]};

  assign valid_op = pop;
  assign option   = pop ? head[SIZE-1:0] : '0;
  assign is_hdr   = pop && head[SIZE];
  assign started  = (state_reg == S_START) && !solved;
  assign stuck    = (state_reg == S_STUCK);
  assign done     = (state_reg == S_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LOAD:  if (load_done) state_next = (count_reg == '0 && !accept) ? S_STUCK : S_START;
      S_START: state_next = solved ? S_DONE : S_RUN;
      S_RUN: begin
        if (solved)                          state_next = S_DONE;
        else if (pass_close && !drop_flag_reg) state_next = S_STUCK;
      end
      S_STUCK: if (solved) state_next = S_DONE;
      default: state_next = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
    if (issue_opt) pend[pend_wr_reg] <= head[SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_LOAD;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      inflight_reg  <= '0;
      pend_rd_reg   <= '0;
      pend_wr_reg   <= '0;
      drop_flag_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (accept)    count_reg <= count_reg + CNT_ONE;
      else if (drop) count_reg <= count_reg - CNT_ONE;
      if (issue_opt && !verdict)      inflight_reg <= inflight_reg + INF_ONE;
      else if (!issue_opt && verdict) inflight_reg <= inflight_reg - INF_ONE;
      if (issue_opt) pend_wr_reg <= (pend_wr_reg == PND_LAST) ? '0 : pend_wr_reg + PND_ONE;
      if (verdict)   pend_rd_reg <= (pend_rd_reg == PND_LAST) ? '0 : pend_rd_reg + PND_ONE;
      if (pass_close) drop_flag_reg <= 1'b0;
      else if (drop)  drop_flag_reg <= 1'b1;
    end
  end

`ifdef SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pass_close && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF)       drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
